// File: rtl/sprite_motion_if.sv
// Control and status bundle for the bouncing-block motion controller.
// Signal names are from the controller's point of view (i_ = into it, o_ = out of it).
interface sprite_motion_if #(
   parameter int X_BITS = 12,
   parameter int Y_BITS = 12
);
   logic              i_vs_in;
   logic              i_run_en;
   logic              i_step_req;
   logic              i_home_req;
   logic [3:0]        i_speed_x;
   logic [3:0]        i_speed_y;
   logic [X_BITS-1:0] o_block_x;
   logic [Y_BITS-1:0] o_block_y;
   logic              o_h_dir;
   logic              o_v_dir;
   logic              o_upd_done;
   logic              o_busy;
   logic [15:0]       o_frame_cnt;

   modport master (
      output i_vs_in, i_run_en, i_step_req, i_home_req, i_speed_x, i_speed_y,
      input  o_block_x, o_block_y, o_h_dir, o_v_dir, o_upd_done, o_busy, o_frame_cnt
   );

   modport slave (
      input  i_vs_in, i_run_en, i_step_req, i_home_req, i_speed_x, i_speed_y,
      output o_block_x, o_block_y, o_h_dir, o_v_dir, o_upd_done, o_busy, o_frame_cnt
   );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Moves a square block once per frame (or once per step request), bouncing off the borders.
// state    | meaning
// IDLE     | parked; waits for run_en or a pending single step
// WAIT_VS  | armed; waits for a vsync rising edge
// CALC     | next position/direction computed from latched speeds
// COMMIT   | both coordinates and directions written together
module sprite_motion_ctrl #(
   parameter int X_BITS  = 12,
   parameter int Y_BITS  = 12,
   parameter int H_ACT   = 1280,
   parameter int V_ACT   = 720,
   parameter int SIDE_W  = 40,
   parameter int BLOCK_W = 40
) (
   input  logic            i_pix_clk,
   input  logic            i_rst,
   sprite_motion_if.slave  bus
);
   localparam int X_MIN = SIDE_W;
   localparam int X_MAX = H_ACT - SIDE_W - BLOCK_W;
   localparam int Y_MIN = SIDE_W;
   localparam int Y_MAX = V_ACT - SIDE_W - BLOCK_W;

   localparam logic [X_BITS-1:0] X_MIN_C = X_BITS'(X_MIN);
   localparam logic [X_BITS-1:0] X_MAX_C = X_BITS'(X_MAX);
   localparam logic [Y_BITS-1:0] Y_MIN_C = Y_BITS'(Y_MIN);
   localparam logic [Y_BITS-1:0] Y_MAX_C = Y_BITS'(Y_MAX);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_CALC, S_COMMIT} state_t;

   state_t            r_state, w_state_nxt;
   logic              r_vs_q, w_vs_rise;
   logic [15:0]       r_frame_cnt;
   logic              r_step_pend, r_home_pend, r_upd_done;
   logic [3:0]        r_spd_x, r_spd_y;
   logic [X_BITS-1:0] r_block_x, r_nx, w_nx;
   logic [Y_BITS-1:0] r_block_y, r_ny, w_ny;
   logic              r_h_dir, r_v_dir, r_nhd, r_nvd, w_nhd, w_nvd;
   logic [X_BITS:0]   w_sum_x, w_lo_x;
   logic [Y_BITS:0]   w_sum_y, w_lo_y;

   assign w_vs_rise = bus.i_vs_in & ~r_vs_q;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (bus.i_run_en || r_step_pend) w_state_nxt = S_WAIT_VS;
         S_WAIT_VS: begin
            if (w_vs_rise)                             w_state_nxt = S_CALC;
            else if (!bus.i_run_en && !r_step_pend)    w_state_nxt = S_IDLE;
         end
         S_CALC:    w_state_nxt = S_COMMIT;
         S_COMMIT:  w_state_nxt = bus.i_run_en ? S_WAIT_VS : S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Widened sums so an overshoot past the far border is never lost to wrap-around.
   always_comb begin
      w_sum_x = {1'b0, r_block_x} + (X_BITS+1)'(r_spd_x);
      w_lo_x  = (X_BITS+1)'(X_MIN) + (X_BITS+1)'(r_spd_x);
      w_nx    = r_block_x;
      w_nhd   = r_h_dir;
      if (r_spd_x != 4'd0) begin
         if (r_h_dir) begin
            if (w_sum_x >= (X_BITS+1)'(X_MAX)) begin
               w_nx  = X_MAX_C;
               w_nhd = 1'b0;
            end else begin
               w_nx  = w_sum_x[X_BITS-1:0];
            end
         end else if ({1'b0, r_block_x} < w_lo_x) begin
            w_nx  = X_MIN_C;
            w_nhd = 1'b1;
         end else begin
            w_nx  = r_block_x - X_BITS'(r_spd_x);
         end
      end
   end

   always_comb begin
      w_sum_y = {1'b0, r_block_y} + (Y_BITS+1)'(r_spd_y);
      w_lo_y  = (Y_BITS+1)'(Y_MIN) + (Y_BITS+1)'(r_spd_y);
      w_ny    = r_block_y;
      w_nvd   = r_v_dir;
      if (r_spd_y != 4'd0) begin
         if (r_v_dir) begin
            if (w_sum_y >= (Y_BITS+1)'(Y_MAX)) begin
               w_ny  = Y_MAX_C;
               w_nvd = 1'b0;
            end else begin
               w_ny  = w_sum_y[Y_BITS-1:0];
            end
         end else if ({1'b0, r_block_y} < w_lo_y) begin
            w_ny  = Y_MIN_C;
            w_nvd = 1'b1;
         end else begin
            w_ny  = r_block_y - Y_BITS'(r_spd_y);
         end
      end
   end

   always_ff @(posedge i_pix_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_vs_q      <= 1'b0;
         r_frame_cnt <= 16'd0;
         r_step_pend <= 1'b0;
         r_home_pend <= 1'b0;
         r_upd_done  <= 1'b0;
         r_spd_x     <= 4'd0;
         r_spd_y     <= 4'd0;
         r_block_x   <= X_MIN_C;
         r_block_y   <= Y_MIN_C;
         r_h_dir     <= 1'b1;
         r_v_dir     <= 1'b1;
         r_nx        <= X_MIN_C;
         r_ny        <= Y_MIN_C;
         r_nhd       <= 1'b1;
         r_nvd       <= 1'b1;
      end else begin
         r_vs_q     <= bus.i_vs_in;
         r_state    <= w_state_nxt;
         r_upd_done <= 1'b0;
         if (w_vs_rise) r_frame_cnt <= r_frame_cnt + 16'd1;
         if (bus.i_step_req && !bus.i_run_en) r_step_pend <= 1'b1;
         case (r_state)
            S_IDLE, S_WAIT_VS: begin
               if (bus.i_home_req) begin
                  r_block_x <= X_MIN_C;
                  r_block_y <= Y_MIN_C;
                  r_h_dir   <= 1'b1;
                  r_v_dir   <= 1'b1;
               end
               if (r_state == S_WAIT_VS && w_vs_rise) begin
                  r_spd_x <= bus.i_speed_x;
                  r_spd_y <= bus.i_speed_y;
               end
            end
            S_CALC: begin
               r_nx  <= w_nx;
               r_ny  <= w_ny;
               r_nhd <= w_nhd;
               r_nvd <= w_nvd;
               if (bus.i_home_req) r_home_pend <= 1'b1;
            end
            S_COMMIT: begin
               if (r_home_pend || bus.i_home_req) begin
                  r_block_x <= X_MIN_C;
                  r_block_y <= Y_MIN_C;
                  r_h_dir   <= 1'b1;
                  r_v_dir   <= 1'b1;
               end else begin
                  r_block_x <= r_nx;
                  r_block_y <= r_ny;
                  r_h_dir   <= r_nhd;
                  r_v_dir   <= r_nvd;
               end
               r_upd_done  <= 1'b1;
               r_home_pend <= 1'b0;
               r_step_pend <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_block_x   = r_block_x;
   assign bus.o_block_y   = r_block_y;
   assign bus.o_h_dir     = r_h_dir;
   assign bus.o_v_dir     = r_v_dir;
   assign bus.o_upd_done  = r_upd_done;
   assign bus.o_busy      = (r_state == S_CALC) || (r_state == S_COMMIT);
   assign bus.o_frame_cnt = r_frame_cnt;
endmodule
